// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared constants, FSM state type and trim encoding for the PLL trim controller
package pll_ctrl_pkg;
  localparam int TRIM_W = 26;
  localparam int LEVEL_MAX = 26;
  localparam int LEVEL_W = 5;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, UPDATE} state_t;
  function automatic logic [TRIM_W-1:0] therm(input logic [LEVEL_W-1:0] lvl);
    logic [TRIM_W-1:0] t;
    for (int k = 0; k < TRIM_W; k++) t[k] = (k < int'(lvl));
    return t;
  endfunction
endpackage

// File: rtl/pll_trim_controller_if.sv
// pll_trim_controller_if: control, reference and trim signals of the trim controller
interface pll_trim_controller_if
  import pll_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic              enable;
  logic              dco;
  logic              osc;
  logic [CNT_W-1:0]  div;
  logic [TRIM_W-1:0] ext_trim;
  logic [TRIM_W-1:0] trim;
  logic [LEVEL_W-1:0] level;
  logic              locked;
  modport master (output enable, dco, osc, div, ext_trim, input trim, level, locked);
  modport slave (input enable, dco, osc, div, ext_trim, output trim, level, locked);
endinterface

// File: rtl/pll_edge_sync.sv
// pll_edge_sync: two-flop synchronizer plus registered rising-edge detect for the reference clock
module pll_edge_sync (
  input  logic clock,
  input  logic resetb,
  input  logic osc_i,
  output logic osc_edge_o
);
  logic [2:0] sync_q;
  logic       edge_q;
  // sync_q[1:0] is the synchronizer, sync_q[2] the previous sample for edge detect
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], osc_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  assign osc_edge_o = edge_q;
endmodule

// File: rtl/pll_trim_controller.sv
// pll_trim_controller: measures DCO cycles per reference period and steps a thermometer trim toward div
module pll_trim_controller
  import pll_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOL = 1,
  parameter int LOCK_N = 4
) (
  input logic clock,
  input logic resetb,
  pll_trim_controller_if.slave bus
);
  localparam int LK_W = $clog2(LOCK_N + 1);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, cnt_inc;
  logic [LK_W-1:0]    lock_q, lock_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TRIM_W-1:0]  trim_q, trim_d;
  logic               locked_q, osc_edge, run, fast, slow;
  logic [CNT_W:0]     per_x, div_x;
  pll_edge_sync u_sync (
    .clock      (clock),
    .resetb     (resetb),
    .osc_i      (bus.osc),
    .osc_edge_o (osc_edge)
  );
  assign run     = bus.enable & ~bus.dco;
  assign per_x   = {1'b0, period_q};
  assign div_x   = {1'b0, bus.div};
  assign fast    = per_x > div_x + (CNT_W+1)'(TOL);
  assign slow    = per_x + (CNT_W+1)'(TOL) < div_x;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  // next state: measure between synchronized osc edges, adjust level once per period
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lock_d   = lock_q;
    level_d  = level_q;
    trim_d   = bus.dco ? bus.ext_trim : therm(level_q);
    if (!run) begin
      state_d = IDLE;
      lock_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          state_d = osc_edge ? MEASURE : ARM;
          cnt_d   = osc_edge ? CNT_W'(1) : cnt_q;
        end
        MEASURE: begin
          state_d  = osc_edge ? UPDATE : MEASURE;
          cnt_d    = osc_edge ? CNT_W'(1) : cnt_inc;
          period_d = osc_edge ? cnt_q : period_q;
        end
        default: begin
          state_d = MEASURE;
          cnt_d   = cnt_inc;
          level_d = fast ? ((level_q == LEVEL_W'(LEVEL_MAX)) ? level_q : level_q + 1'b1)
                  : slow ? ((level_q == '0) ? level_q : level_q - 1'b1)
                  : level_q;
          lock_d  = (fast | slow) ? '0 : ((lock_q == LK_W'(LOCK_N)) ? lock_q : lock_q + 1'b1);
        end
      endcase
    end
  end
  // state and datapath registers; locked follows the next lock count so it drops right after a bad update
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      lock_q   <= '0;
      level_q  <= '0;
      trim_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lock_q   <= lock_d;
      level_q  <= level_d;
      trim_q   <= trim_d;
      locked_q <= (lock_d == LK_W'(LOCK_N));
    end
  assign bus.trim   = trim_q;
  assign bus.level  = level_q;
  assign bus.locked = locked_q;
endmodule
